// File: rtl/pipe_mem_arbiter.sv
// Shared single-port memory arbiter between an instruction fetch stage and a
// MEM stage: one outstanding bus transaction at a time, MEM has priority.
module pipe_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        combined_stall,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t     state, state_next;
  owner_t     owner, owner_next;
  logic [7:0] count, count_next;
  logic       discard, discard_next;
  logic       latch_mem, latch_if;
  logic       timeout, done, if_drop;

  // The timeout fires on the TIMEOUT-th DATA cycle that passes without a
  // response, i.e. when the count of empty cycles already seen is TIMEOUT-1.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  assign timeout = (state == DATA) && !bus_rvalid && (count == LIMIT);
  assign done    = (state == DATA) && (bus_rvalid || timeout);
  assign if_drop = if_flush || discard;

  assign bus_req   = (state == ADDR);
  assign bus_err   = timeout;
  assign if_valid  = done && (owner == OWN_IF) && !if_drop;
  assign mem_valid = done && (owner == OWN_MEM);
  assign if_rdata  = timeout ? 32'h0000_0013 : bus_rdata;
  assign mem_rdata = timeout ? 32'h0000_0000 : bus_rdata;

  assign combined_stall = (mem_req && !mem_valid) || (if_req && !if_flush && !if_valid);

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    count_next   = count;
    discard_next = discard;
    latch_mem    = 1'b0;
    latch_if     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          latch_mem  = 1'b1;
          owner_next = OWN_MEM;
          state_next = ADDR;
        end else if (if_req && !if_flush) begin
          latch_if   = 1'b1;
          owner_next = OWN_IF;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (owner == OWN_IF && if_flush) begin
          state_next = IDLE;
        end else if (bus_gnt) begin
          state_next   = DATA;
          count_next   = 8'd0;
          discard_next = 1'b0;
        end
      end
      DATA: begin
        if (done) begin
          state_next = IDLE;
        end else begin
          count_next = count + 8'd1;
        end
        // A redirected fetch still has to drain its response from the bus.
        if (owner == OWN_IF && if_flush) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      count   <= 8'd0;
      discard <= 1'b0;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      count   <= count_next;
      discard <= discard_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_wstrb <= 4'd0;
    end else if (latch_mem) begin
      bus_we    <= mem_we;
      bus_addr  <= mem_addr;
      bus_wdata <= mem_wdata;
      bus_wstrb <= mem_wstrb;
    end else if (latch_if) begin
      bus_we    <= 1'b0;
      bus_addr  <= if_addr;
      bus_wdata <= 32'd0;
      bus_wstrb <= 4'd0;
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Randomized bench for pipe_mem_arbiter: a driver plays both pipeline stages
// and the memory, pushing expectations that a negedge monitor checks.
module tb_pipe_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = 32'd0, mem_addr = 32'd0, mem_wdata = 32'd0, bus_rdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic        if_valid, mem_valid, bus_req, bus_we, combined_stall, bus_err;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  pipe_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .combined_stall(combined_stall), .bus_err(bus_err)
  );

  typedef struct { int due; bit iv; bit mv; bit err; logic [31:0] data; } resp_t;
  typedef struct { bit is_mem; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } breq_t;

  resp_t resp_q[$];
  breq_t bus_q[$];
  resp_t mon_r;
  breq_t mon_b;
  int    passed = 0, total = 0, cyc = 0;
  bit    mon_on = 1'b0;

  logic [31:0] nx_if_addr, nx_mem_addr, nx_mem_wdata;
  logic        nx_mem_we;
  logic [3:0]  nx_mem_wstrb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word_addr();
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // Monitor: responses are due on an exact cycle; any other pulse is an error.
  always @(negedge clk) begin
    if (!reset && mon_on) begin
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        mon_r = resp_q.pop_front();
        check("if_valid", {31'd0, if_valid}, {31'd0, mon_r.iv});
        check("mem_valid", {31'd0, mem_valid}, {31'd0, mon_r.mv});
        check("bus_err", {31'd0, bus_err}, {31'd0, mon_r.err});
        if (mon_r.iv) check("if_rdata", if_rdata, mon_r.data);
        if (mon_r.mv && (mon_r.err || !bus_we)) check("mem_rdata", mem_rdata, mon_r.data);
      end else if (if_valid || mem_valid || bus_err) begin
        total++;
        $display("FAIL unexpected_response: if_valid=%b mem_valid=%b bus_err=%b at cycle %0d, want none",
                 if_valid, mem_valid, bus_err, cyc);
      end
      if (bus_req) begin
        if (bus_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_bus_req: bus_req=1 addr=%h, want bus_req=0", bus_addr);
        end else begin
          mon_b = bus_q[0];
          check("bus_addr", bus_addr, mon_b.addr);
          check("bus_we", {31'd0, bus_we}, {31'd0, mon_b.we});
          if (mon_b.is_mem) begin
            check("bus_wdata", bus_wdata, mon_b.wdata);
            check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, mon_b.wstrb});
          end
          if (bus_gnt) void'(bus_q.pop_front());
        end
      end
      check("combined_stall", {31'd0, combined_stall},
            {31'd0, (mem_req & ~mem_valid) | (if_req & ~if_flush & ~if_valid)});
    end
  end

  // mode: 0 random, 1 zero-wait fetch, 2 grant after 4 cycles,
  //       3 forced timeout, 4 fetch flushed in DATA with response 2 cycles later
  task automatic round(input bit wm, input bit wi, input int mode);
    bit pm, pi, flushed_once;
    pm = wm; pi = wi; flushed_once = 1'b0;
    if (pm) begin
      mem_req = 1'b1; mem_we = nx_mem_we; mem_addr = nx_mem_addr;
      mem_wdata = nx_mem_wdata; mem_wstrb = nx_mem_wstrb;
    end
    if (pi) begin
      if_req = 1'b1; if_addr = nx_if_addr;
    end
    while (pm || pi) begin
      bit own_mem, tmo, disc;
      int gd, rd, ft, fa, fd, n;
      logic [31:0] rdat;
      breq_t b;
      resp_t r;
      own_mem = pm;
      disc = 1'b0;
      gd   = (mode == 2) ? 4 : (mode == 0) ? $urandom_range(0, 3) : 0;
      tmo  = (mode == 3) || (mode == 0 && $urandom_range(0, 5) == 0);
      rd   = (mode == 4) ? 2 : (mode == 0) ? $urandom_range(0, TO - 1) : 0;
      ft   = (own_mem || flushed_once) ? 0 : (mode == 4) ? 2 : (mode == 0) ? $urandom_range(0, 3) : 0;
      rdat = (mode == 1) ? 32'h0050_0093 : $urandom;
      fa   = $urandom_range(0, gd);
      fd   = (mode == 4) ? 0 : $urandom_range(0, tmo ? TO - 1 : rd);

      b.is_mem = own_mem;
      b.we     = own_mem ? mem_we : 1'b0;
      b.addr   = own_mem ? mem_addr : if_addr;
      b.wdata  = mem_wdata;
      b.wstrb  = mem_wstrb;
      bus_q.push_back(b);
      bus_gnt = 1'($urandom);
      bus_rvalid = 1'($urandom);
      step();

      // Fields are only sampled in IDLE, so scramble them now.
      if (own_mem) begin
        mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
      end else begin
        if_addr = $urandom;
      end

      for (int i = 0; i <= gd; i++) begin
        bus_rvalid = 1'($urandom);
        bus_rdata  = $urandom;
        if (ft == 1 && i == fa) begin
          if_flush = 1'b1;
          bus_gnt  = 1'b0;
          break;
        end
        bus_gnt = (i == gd);
        step();
      end
      if (ft == 1) begin
        step();
        if_flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        check("flush_drops_bus_req", {31'd0, bus_req}, 32'd0);
        void'(bus_q.pop_front());
        if_addr = rand_word_addr();
        flushed_once = 1'b1;
        continue;
      end

      n = tmo ? TO : rd + 1;
      for (int j = 0; j < n; j++) begin
        bus_gnt    = 1'($urandom);
        bus_rvalid = !tmo && (j == rd);
        bus_rdata  = (j == n - 1) ? rdat : $urandom;
        if (ft == 2 && j == fd) begin
          if_flush = 1'b1; disc = 1'b1;
        end else begin
          if_flush = 1'b0;
        end
        if (j == n - 1) begin
          r.due = cyc;
          r.mv  = own_mem;
          r.err = tmo;
          r.iv  = !own_mem && !disc;
          r.data = tmo ? (own_mem ? 32'h0 : 32'h0000_0013) : rdat;
          if (r.iv || r.mv || r.err) resp_q.push_back(r);
        end
        step();
      end
      if_flush = 1'b0; bus_rvalid = 1'b0; bus_gnt = 1'b0;

      if (own_mem) begin
        pm = 1'b0; mem_req = 1'b0;
      end else if (ft == 2) begin
        flushed_once = 1'b1;
        if_addr = rand_word_addr();
      end else begin
        pi = 1'b0; if_req = 1'b0;
      end
    end
  endtask

  task automatic rand_fields();
    nx_if_addr   = rand_word_addr();
    nx_mem_addr  = rand_word_addr();
    nx_mem_wdata = $urandom;
    nx_mem_we    = 1'($urandom);
    nx_mem_wstrb = 4'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    mon_on = 1'b1;

    rand_fields(); nx_if_addr = 32'h100;
    round(1'b0, 1'b1, 1);
    rand_fields(); nx_mem_addr = 32'h2000; nx_mem_we = 1'b0;
    round(1'b1, 1'b1, 0);
    rand_fields(); nx_mem_addr = 32'h40; nx_mem_we = 1'b1;
    nx_mem_wdata = 32'hDEAD_BEEF; nx_mem_wstrb = 4'b0011;
    round(1'b1, 1'b0, 2);
    rand_fields();
    round(1'b0, 1'b1, 4);
    rand_fields();
    round(1'b0, 1'b1, 3);
    rand_fields();
    round(1'b1, 1'b0, 3);

    for (int k = 0; k < 150; k++) begin
      bit wm, wi;
      rand_fields();
      wm = 1'($urandom);
      wi = !wm || 1'($urandom);
      round(wm, wi, 0);
      repeat ($urandom_range(0, 2)) begin
        bus_rvalid = 1'($urandom);
        bus_gnt = 1'($urandom);
        step();
      end
      bus_rvalid = 1'b0; bus_gnt = 1'b0;
    end

    // Reset while a fetch sits in ADDR, then a stray response after release.
    if_addr = 32'h0000_0200; if_req = 1'b1;
    bus_q.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h200, wdata: 32'h0, wstrb: 4'h0});
    step();
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    void'(bus_q.pop_front());
    if_req = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    bus_rvalid = 1'b0;
    repeat (3) step();

    check("resp_queue_drained", resp_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
